data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Memory-side responder for the pipelined core's M-stage data interface.
- The core drives a byte address, write data and a write strobe. This block returns read data combinationally in the same cycle.
- The lower address range is a word RAM. The top 16 bytes are MMIO registers: a cycle counter, a scratch register, a debug output FIFO with a valid/ready drain port, and a sticky halt register used to end test programs.

Parameters:
n, 10, byte address width; RAM spans 2^n bytes minus the MMIO window
m, 32, data width; fixed at 32 for this revision
FIFO_DEPTH, 4, debug FIFO entries; power of 2, minimum 2

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-low (rst==0 at a rising edge resets)
addr  in  n  byte address from core (ALUoutM[n-1:0]); bits [1:0] ignored
write_dataM  in  m  store data
memwrM  in  1  write strobe, sampled at rising edge
read_dataM  out  m  combinational read data for addr
dbg_data  out  m  FIFO head word
dbg_valid  out  1  FIFO non-empty
dbg_ready  in  1  consumer accepts head when dbg_valid&&dbg_ready
halted  out  1  sticky halt flag
halt_code  out  8  code captured on halt

Behaviour:
- Word index is addr[n-1:2]. All accesses are full-word; misaligned low bits are ignored.
- MMIO window is the top 4 words (n=10: 0x3F0-0x3FF). Everything below is RAM: 2^(n-2)-4 words.
- RAM read is combinational from the current addr. A write commits at the rising edge when memwrM=1.
- A read and write to the same address in the same cycle returns the old value.
- RAM contents are not cleared by reset.

MMIO map (offset from window base):
- +0x0 CYCLE (RO): 32-bit counter. Reset 0, +1 every cycle rst=1, wraps 0xFFFFFFFF->0. Writes ignored.
- +0x4 SCRATCH (RW): reset 0; write stores full word.
- +0x8 DBG:
  - Write pushes write_dataM into the FIFO.
  - Read returns {27'b0, overflow, full, empty, 2'b0} in bits [4:0]: bit4=overflow, bit3=full, bit2=empty.
  - For FIFO_DEPTH>4, count appears in bits [31:8].
- +0xC HALT:
  - Write sets halted=1 and halt_code=write_dataM[7:0].
  - While halted=1, further HALT writes are ignored. Read returns {23'b0, halted, halt_code}.

FIFO:
- Pointer-based circular buffer with count.
- dbg_data shows the head entry. It is don't-care when empty; the model must drive the head register anyway.
- Pop when dbg_valid&&dbg_ready.
- Push is accepted if not full, or if full and a pop occurs in the same cycle.
- A push into a full FIFO without a pop is dropped and sets sticky overflow. Overflow is cleared only by reset.
- No bypass: a push into an empty FIFO raises dbg_valid the next cycle.
- Simultaneous push and pop when non-empty leaves count unchanged.
- Pointers wrap modulo FIFO_DEPTH.

Reset values (rst=0 at edge, including mid-operation):
- CYCLE=0, SCRATCH=0, FIFO emptied (dbg_valid=0, pointers/count 0), overflow=0, halted=0, halt_code=0.
- A write presented in the reset cycle is discarded for MMIO and RAM alike.
- read_dataM stays combinational during reset; CYCLE reads 0 after reset.

Other timing and rules:
- memwrM=0: no state changes except CYCLE increment and FIFO pop.
- RAM writes continue after halt; the core is expected to stop, but the block does not enforce it.

Test Plan:
- Reset, then write 0xDEADBEEF @0x004 and 0x12345678 @0x3EC; read both back -> exact values. Write+read @0x004 in the same cycle with 0x1 -> read returns 0xDEADBEEF, next cycle returns 0x1.
- Release reset, idle 10 cycles, read 0x3F0 -> 10 (±0 against the reference model). Write 0x3F0 -> counter unaffected. Force CYCLE near 0xFFFFFFFF via long run or a bench-only preset -> wraps to 0.
- dbg_ready=0, push 0xA,0xB,0xC,0xD,0xE -> status full=1, overflow=1. Set dbg_ready=1 -> dbg_data drains 0xA..0xD in order, then dbg_valid=0, empty=1, overflow still 1.
- FIFO full with dbg_ready=1 and push 0x55 in the same cycle -> no overflow, 0x55 drains last. Push into empty FIFO -> dbg_valid=0 that cycle, 1 the next.
- Write HALT 0x2A -> halted=1, halt_code=0x2A, read 0x3FC = 0x12A. Write HALT 0x07 -> halt_code unchanged.
- Mid-operation reset with FIFO 3 deep, SCRATCH=0x99, halted=1, and memwrM=1 to SCRATCH with 0x77 in the reset cycle -> all MMIO back to reset values, SCRATCH reads 0, RAM contents preserved.

Source files
------------

// File: rtl/data_mem_responder.sv
// Data-side memory responder: word RAM plus a small MMIO window
// holding a cycle counter, scratch, debug FIFO and halt register.
module data_mem_responder #(
  parameter int n          = 10,
  parameter int m          = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [n-1:0] addr,
  input  logic [m-1:0] write_dataM,
  input  logic         memwrM,
  output logic [m-1:0] read_dataM,
  output logic [m-1:0] dbg_data,
  output logic         dbg_valid,
  input  logic         dbg_ready,
  output logic         halted,
  output logic [7:0]   halt_code
);

  localparam int WORDS     = 2 ** (n - 2);
  localparam int RAM_WORDS = WORDS - 4;
  localparam int PW        = $clog2(FIFO_DEPTH);
  localparam int CW        = PW + 1;

  logic [n-3:0] wordIdx;
  logic         isMmio;
  logic [1:0]   regSel;
  logic         selRam;
  logic         selCycle;
  logic         selScratch;
  logic         selDbg;
  logic         selHalt;
  logic         unusedLowBits;

  logic [m-1:0] ram [RAM_WORDS];
  logic [m-1:0] ramRd;

  logic [m-1:0] cycleCnt;
  logic [m-1:0] scratch;
  logic [7:0]   haltCode;
  logic         haltFlag;

  logic [m-1:0] fifoMem [FIFO_DEPTH];
  logic [PW-1:0] headPtr;
  logic [PW-1:0] tailPtr;
  logic [CW-1:0] count;
  logic          overflow;
  logic          fifoFull;
  logic          fifoEmpty;
  logic          push;
  logic          pop;
  logic          pushOk;
  logic          pushDrop;
  logic [m-1:0]  dbgStatus;

  assign wordIdx       = addr[n-1:2];
  assign isMmio        = &addr[n-1:4];
  assign regSel        = addr[3:2];
  assign unusedLowBits = ^addr[1:0];

  assign selRam     = !isMmio;
  assign selCycle   = isMmio && (regSel == 2'd0);
  assign selScratch = isMmio && (regSel == 2'd1);
  assign selDbg     = isMmio && (regSel == 2'd2);
  assign selHalt    = isMmio && (regSel == 2'd3);

  assign ramRd = ram[wordIdx];

  assign fifoFull  = (count == CW'(FIFO_DEPTH));
  assign fifoEmpty = (count == '0);
  assign pop       = !fifoEmpty && dbg_ready;
  assign push      = memwrM && selDbg;
  assign pushOk    = push && (!fifoFull || pop);
  assign pushDrop  = push && fifoFull && !pop;

  assign dbg_data  = fifoMem[headPtr];
  assign dbg_valid = !fifoEmpty;
  assign halted    = haltFlag;
  assign halt_code = haltCode;

  // RAM store; contents survive reset, stores in a reset cycle are lost
  always_ff @(posedge clk) begin
    if (rst && memwrM && selRam) begin
      ram[wordIdx] <= write_dataM;
    end
  end

  // Free-running cycle counter, wraps naturally
  always_ff @(posedge clk) begin
    if (!rst) begin
      cycleCnt <= '0;
    end else begin
      cycleCnt <= cycleCnt + m'(1);
    end
  end

  // Scratch register and sticky halt capture
  always_ff @(posedge clk) begin
    if (!rst) begin
      scratch  <= '0;
      haltFlag <= 1'b0;
      haltCode <= '0;
    end else if (memwrM) begin
      if (selScratch) begin
        scratch <= write_dataM;
      end
      if (selHalt && !haltFlag) begin
        haltFlag <= 1'b1;
        haltCode <= write_dataM[7:0];
      end
    end
  end

  // FIFO storage; a full FIFO may still accept when it pops this cycle
  always_ff @(posedge clk) begin
    if (rst && pushOk) begin
      fifoMem[tailPtr] <= write_dataM;
    end
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (!rst) begin
      headPtr  <= '0;
      tailPtr  <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (pop) begin
        headPtr <= headPtr + PW'(1);
      end
      if (pushOk) begin
        tailPtr <= tailPtr + PW'(1);
      end
      if (pushOk && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !pushOk) begin
        count <= count - CW'(1);
      end
      if (pushDrop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Debug status word; occupancy only exposed for deeper FIFOs
  always_comb begin
    dbgStatus    = '0;
    dbgStatus[4] = overflow;
    dbgStatus[3] = fifoFull;
    dbgStatus[2] = fifoEmpty;
    if (FIFO_DEPTH > 4) begin
      dbgStatus[31:8] = 24'(count);
    end
  end

  // Combinational read mux over RAM and MMIO registers
  always_comb begin
    read_dataM = '0;
    unique case (1'b1)
      selRam:     read_dataM = ramRd;
      selCycle:   read_dataM = cycleCnt;
      selScratch: read_dataM = scratch;
      selDbg:     read_dataM = dbgStatus;
      selHalt:    read_dataM = m'({haltFlag, haltCode});
      default:    read_dataM = '0;
    endcase
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed table, corner sequences
// and random traffic against a queue/array reference model.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic [9:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic        memwr = 1'b0;
  logic        ready = 1'b0;
  logic [31:0] readData;
  logic [31:0] dbgData;
  logic        dbgValid;
  logic        halted;
  logic [7:0]  haltCode;

  data_mem_responder dut (
    .clk        (clk),
    .rst        (rstN),
    .addr       (addr),
    .write_dataM(wdata),
    .memwrM     (memwr),
    .read_dataM (readData),
    .dbg_data   (dbgData),
    .dbg_valid  (dbgValid),
    .dbg_ready  (ready),
    .halted     (halted),
    .halt_code  (haltCode)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;

  logic [31:0] mRam [252];
  bit          mKnown [252];
  logic [31:0] mCycle = '0;
  logic [31:0] mScratch = '0;
  logic [31:0] mQ [$];
  bit          mOvf = 0;
  bit          mHalt = 0;
  logic [7:0]  mCode = '0;

  logic [31:0] lastRd;
  logic [31:0] lastData;
  logic        lastValid;
  logic        lastHalt;
  logic [7:0]  lastCode;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [9:0] a,
                      input logic [31:0] d, input logic we,
                      input logic rdy);
    int idx;
    int sz;
    bit popped;
    logic [31:0] exp;
    @(negedge clk);
    rstN = r; addr = a; wdata = d; memwr = we; ready = rdy;
    #1;
    idx = int'(a[9:2]);
    if (idx < 252) begin
      if (mKnown[idx]) check("ram_read", readData, mRam[idx]);
    end else begin
      case (a[3:2])
        2'd0: exp = mCycle;
        2'd1: exp = mScratch;
        2'd2: exp = {27'b0, mOvf, mQ.size() == 4, mQ.size() == 0, 2'b0};
        default: exp = {23'b0, mHalt, mCode};
      endcase
      check("mmio_read", readData, exp);
    end
    check("dbg_valid", 32'(dbgValid), 32'(mQ.size() != 0));
    if (mQ.size() != 0) check("dbg_data", dbgData, mQ[0]);
    check("halted", 32'(halted), 32'(mHalt));
    check("halt_code", 32'(haltCode), 32'(mCode));
    lastRd = readData; lastData = dbgData; lastValid = dbgValid;
    lastHalt = halted; lastCode = haltCode;
    @(posedge clk);
    if (!r) begin
      mCycle = '0; mScratch = '0; mQ.delete();
      mOvf = 0; mHalt = 0; mCode = '0;
    end else begin
      mCycle = mCycle + 1;
      sz = mQ.size();
      popped = (sz != 0) && rdy;
      if (popped) void'(mQ.pop_front());
      if (we) begin
        if (idx < 252) begin
          mRam[idx] = d;
          mKnown[idx] = 1;
        end else begin
          case (a[3:2])
            2'd1: mScratch = d;
            2'd2: if (sz < 4 || popped) mQ.push_back(d); else mOvf = 1;
            2'd3: if (!mHalt) begin mHalt = 1; mCode = d[7:0]; end
            default: ;
          endcase
        end
      end
    end
  endtask

  typedef struct {
    logic [9:0]  a;
    logic [31:0] d;
    logic        we;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [11];
  logic [31:0] drainExp [4];

  initial begin
    tbl[0]  = '{10'h004, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0};
    tbl[1]  = '{10'h3EC, 32'h12345678, 1'b1, 1'b0, 32'h0};
    tbl[2]  = '{10'h004, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF};
    tbl[3]  = '{10'h3EC, 32'h0,        1'b0, 1'b1, 32'h12345678};
    tbl[4]  = '{10'h004, 32'h1,        1'b1, 1'b1, 32'hDEADBEEF};
    tbl[5]  = '{10'h006, 32'h0,        1'b0, 1'b1, 32'h1};
    tbl[6]  = '{10'h3F4, 32'hCAFEF00D, 1'b1, 1'b1, 32'h0};
    tbl[7]  = '{10'h3F4, 32'h0,        1'b0, 1'b1, 32'hCAFEF00D};
    tbl[8]  = '{10'h3F7, 32'h0,        1'b0, 1'b1, 32'hCAFEF00D};
    tbl[9]  = '{10'h3F8, 32'h0,        1'b0, 1'b1, 32'h4};
    tbl[10] = '{10'h3FC, 32'h0,        1'b0, 1'b1, 32'h0};

    repeat (2) @(posedge clk);
    step(0, 10'h3F0, 0, 0, 0);
    check("reset_cycle", lastRd, 0);
    check("reset_valid", 32'(lastValid), 0);

    for (int i = 0; i < 11; i++) begin
      step(1, tbl[i].a, tbl[i].d, tbl[i].we, 0);
      if (tbl[i].chk) check($sformatf("tbl%0d", i), lastRd, tbl[i].exp);
    end

    step(0, 10'h0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 10'h0, 0, 0, 0);
    step(1, 10'h3F0, 0, 0, 0);
    check("cycle10", lastRd, 10);
    step(1, 10'h3F0, 32'h0, 1, 0);
    check("cycle11", lastRd, 11);
    step(1, 10'h3F0, 0, 0, 0);
    check("cycle_ro", lastRd, 12);
    #1 force dut.cycleCnt = 32'hFFFF_FFFE;
    #1 release dut.cycleCnt;
    mCycle = 32'hFFFF_FFFE;
    step(1, 10'h3F0, 0, 0, 0);
    check("cycle_pre", lastRd, 32'hFFFF_FFFE);
    step(1, 10'h3F0, 0, 0, 0);
    check("cycle_max", lastRd, 32'hFFFF_FFFF);
    step(1, 10'h3F0, 0, 0, 0);
    check("cycle_wrap", lastRd, 0);

    step(0, 10'h0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 10'h3F8, 32'hA + i, 1, 0);
    step(1, 10'h3F8, 0, 0, 0);
    check("ovf_status", lastRd, 32'h18);
    for (int i = 0; i < 4; i++) begin
      step(1, 10'h3F8, 0, 0, 1);
      check("drain_valid", 32'(lastValid), 1);
      check("drain_data", lastData, 32'hA + i);
    end
    step(1, 10'h3F8, 0, 0, 1);
    check("drained_valid", 32'(lastValid), 0);
    check("drained_status", lastRd, 32'h14);

    step(0, 10'h0, 0, 0, 0);
    step(1, 10'h3F8, 32'h77, 1, 0);
    check("nobypass", 32'(lastValid), 0);
    step(1, 10'h3F8, 32'h11, 1, 0);
    check("valid_next", 32'(lastValid), 1);
    check("head77", lastData, 32'h77);
    step(1, 10'h3F8, 32'h22, 1, 0);
    step(1, 10'h3F8, 32'h33, 1, 0);
    step(1, 10'h3F8, 32'h55, 1, 1);
    check("full_pre", lastRd, 32'h8);
    step(1, 10'h3F8, 0, 0, 0);
    check("full_noovf", lastRd, 32'h8);
    drainExp[0] = 32'h11; drainExp[1] = 32'h22;
    drainExp[2] = 32'h33; drainExp[3] = 32'h55;
    for (int i = 0; i < 4; i++) begin
      step(1, 10'h0, 0, 0, 1);
      check("order", lastData, drainExp[i]);
    end

    step(1, 10'h3FC, 32'h2A, 1, 0);
    step(1, 10'h3FC, 0, 0, 0);
    check("halt_read", lastRd, 32'h12A);
    check("halt_flag", 32'(lastHalt), 1);
    check("halt_code1", 32'(lastCode), 32'h2A);
    step(1, 10'h3FC, 32'h07, 1, 0);
    step(1, 10'h3FC, 0, 0, 0);
    check("halt_sticky", 32'(lastCode), 32'h2A);

    step(1, 10'h3F4, 32'h99, 1, 0);
    step(1, 10'h100, 32'hABCD0123, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 10'h3F8, 32'h40 + i, 1, 0);
    step(1, 10'h3F4, 0, 0, 0);
    check("scratch99", lastRd, 32'h99);
    step(0, 10'h3F4, 32'h77, 1, 0);
    step(1, 10'h3F4, 0, 0, 0);
    check("rst_scratch", lastRd, 0);
    check("rst_valid", 32'(lastValid), 0);
    check("rst_halt", 32'(lastHalt), 0);
    check("rst_code", 32'(lastCode), 0);
    step(1, 10'h3F8, 0, 0, 0);
    check("rst_status", lastRd, 32'h4);
    step(0, 10'h100, 32'hFFFF, 1, 0);
    step(1, 10'h3F0, 0, 0, 0);
    check("rst_cycle", lastRd, 0);
    step(1, 10'h100, 0, 0, 0);
    check("ram_kept", lastRd, 32'hABCD0123);
    step(1, 10'h004, 0, 0, 0);
    check("ram_kept2", lastRd, 32'h1);

    for (int i = 0; i < 600; i++) begin
      int k;
      logic [9:0] a;
      k = $urandom_range(0, 11);
      if (k < 8) a = 10'(10'h200 + k * 4 + $urandom_range(0, 3));
      else a = 10'(10'h3F0 + (k - 8) * 4);
      step($urandom_range(0, 39) != 0, a, $urandom,
           $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFails);
    $finish;
  end

endmodule
